hpm_counter_bank: RTL and testbench

//   Parametrised bank of programmable hardware performance counters (mhpmcounter3..,

---
 rtl/hpm_pkg.sv | 31 +++
 rtl/hpm_counter_slice.sv | 110 +++++++++++
 rtl/hpm_counter_bank.sv | 106 ++++++++++
 tb/tb_hpm_counter_bank.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpm_pkg.sv
// Shared constants for the hardware performance counter bank: CSR address map,
// Sscofpmf-style mhpmevent control bit positions, privilege encodings and the
// event-select width helper.
package hpm_pkg;

    localparam logic [11:0] MHPMCOUNTER_BASE = 12'hB03;
    localparam logic [11:0] HPMCOUNTER_BASE  = 12'hC03;
    localparam logic [11:0] MHPMEVENT_BASE   = 12'h323;
    localparam logic [11:0] SCOUNTOVF_ADDR   = 12'hDA0;

    // First architectural counter index; counter i sits at bit/offset FIRST_IDX+i
    localparam int unsigned FIRST_IDX = 3;
    localparam int unsigned NCNT_MAX  = 29;

    localparam int unsigned OF_BIT   = 63;
    localparam int unsigned MINH_BIT = 62;
    localparam int unsigned SINH_BIT = 61;
    localparam int unsigned UINH_BIT = 60;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_e;

    // Event-select field width: enough to hold 0 (none) through NEVT
    function automatic int unsigned es_width(input int unsigned nevt);
        return $clog2(nevt + 1);
    endfunction

endpackage

// File: rtl/hpm_counter_slice.sv
// One programmable performance counter with its mhpmevent register, event select,
// per-mode filter and overflow flag. Optional feature macro: HPM_OVERFLOW_EN.
module hpm_counter_slice
    import hpm_pkg::*;
#(
    parameter int unsigned CW   = 64,
    parameter int unsigned NEVT = 16,
    parameter int unsigned EIW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cnt_we,
    input  logic                evt_we,
    input  logic [63:0]         wdat,
    input  logic [NEVT*EIW-1:0] evt_s1,
    input  logic [1:0]          level_s1,
    input  logic                inhibit_s1,
    output logic [63:0]         cnt_rd,
    output logic [63:0]         evt_rd,
    output logic                of_bit,
    output logic                lcof
);

    localparam int unsigned ES = es_width(NEVT);
    localparam int unsigned SW = ((CW > EIW) ? CW : EIW) + 1;

    logic [CW-1:0]  cnt_q;
    logic [ES-1:0]  sel_q;
    logic [EIW-1:0] inc;
    logic [SW-1:0]  sum;
    logic           filt;
    logic           count_en;
    logic           unused_c;

    // Pick the increment of the selected event line; out-of-range selects give zero
    always_comb begin
        inc = '0;
        for (int unsigned k = 0; k < NEVT; k++) begin
            if (sel_q == ES'(k + 1)) inc = evt_s1[k*EIW +: EIW];
        end
    end

`ifdef HPM_OVERFLOW_EN
    logic of_q, minh_q, sinh_q, uinh_q, lcof_q;
    logic ovf;

    // Mode filter against the privilege level captured alongside the events
    always_comb begin
        filt = (minh_q && (level_s1 == PRIV_M)) ||
               (sinh_q && (level_s1 == PRIV_S)) ||
               (uinh_q && (level_s1 == PRIV_U));
    end
`else
    assign filt = 1'b0;
`endif

    // A software write to the counter discards the pending increment
    assign count_en = !inhibit_s1 && !filt && !cnt_we;
    assign sum      = SW'(cnt_q) + SW'(inc);

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          cnt_q <= '0;
        else if (cnt_we)   cnt_q <= wdat[CW-1:0];
        else if (count_en) cnt_q <= sum[CW-1:0];
    end

    // Event select register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        sel_q <= '0;
        else if (evt_we) sel_q <= wdat[ES-1:0];
    end

`ifdef HPM_OVERFLOW_EN
    assign ovf = count_en && (sum[SW-1:CW] != '0);

    // Overflow flag and mode-inhibit bits; a coincident overflow beats a software OF write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            of_q   <= 1'b0;
            minh_q <= 1'b0;
            sinh_q <= 1'b0;
            uinh_q <= 1'b0;
            lcof_q <= 1'b0;
        end else begin
            lcof_q <= ovf && !of_q;
            if (evt_we) begin
                of_q   <= wdat[OF_BIT] || ovf;
                minh_q <= wdat[MINH_BIT];
                sinh_q <= wdat[SINH_BIT];
                uinh_q <= wdat[UINH_BIT];
            end else begin
                of_q   <= of_q || ovf;
            end
        end
    end

    assign of_bit = of_q;
    assign lcof   = lcof_q;
    assign evt_rd = {of_q, minh_q, sinh_q, uinh_q, 60'(sel_q)};
`else
    assign of_bit = 1'b0;
    assign lcof   = 1'b0;
    assign evt_rd = 64'(sel_q);
`endif

    assign cnt_rd   = 64'(cnt_q);
    assign unused_c = ^{wdat, sum, level_s1};

endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of NCNT programmable performance counters (mhpmcounter3.., mhpmevent3..).
// Holds the event/level/inhibit sample stage, CSR decode and read mux.
// Optional feature macro: HPM_OVERFLOW_EN (overflow flag, mode filter, LCOF, scountovf).
module hpm_counter_bank
    import hpm_pkg::*;
#(
    parameter int unsigned NCNT = 29,
    parameter int unsigned CW   = 64,
    parameter int unsigned NEVT = 16,
    parameter int unsigned EIW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                csr_we,
    input  logic [11:0]         csr_addr,
    input  logic [63:0]         csr_wdat,
    output logic [63:0]         csr_rdat,
    output logic                csr_hit,
    input  logic [1:0]          level,
    input  logic [NCNT-1:0]     inhibit,
    input  logic [NEVT*EIW-1:0] evt,
    output logic                lcof_set,
    output logic [31:0]         scountovf
);

    localparam int unsigned EW = NEVT * EIW;

    logic [EW-1:0]   evt_s1;
    logic [1:0]      level_s1;
    logic [NCNT-1:0] inhibit_s1;
    logic [NCNT-1:0] cnt_we;
    logic [NCNT-1:0] evt_we;
    logic [NCNT-1:0] of_v;
    logic [NCNT-1:0] lcof_v;
    logic [63:0]     cnt_rd [NCNT];
    logic [63:0]     evt_rd [NCNT];

    // S1 stage: sample the event increments and their qualifiers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_s1     <= '0;
            level_s1   <= '0;
            inhibit_s1 <= '0;
        end else begin
            evt_s1     <= evt;
            level_s1   <= level;
            inhibit_s1 <= inhibit;
        end
    end

    for (genvar i = 0; i < NCNT; i++) begin : g_slice
        assign cnt_we[i] = csr_we && (csr_addr == MHPMCOUNTER_BASE + 12'(i));
        assign evt_we[i] = csr_we && (csr_addr == MHPMEVENT_BASE + 12'(i));

        hpm_counter_slice #(
            .CW   (CW),
            .NEVT (NEVT),
            .EIW  (EIW)
        ) u_slice (
            .clk        (clk),
            .rst        (rst),
            .cnt_we     (cnt_we[i]),
            .evt_we     (evt_we[i]),
            .wdat       (csr_wdat),
            .evt_s1     (evt_s1),
            .level_s1   (level_s1),
            .inhibit_s1 (inhibit_s1[i]),
            .cnt_rd     (cnt_rd[i]),
            .evt_rd     (evt_rd[i]),
            .of_bit     (of_v[i]),
            .lcof       (lcof_v[i])
        );
    end

    // Place each counter's OF at its architectural bit position
    always_comb begin
        scountovf = '0;
        for (int unsigned i = 0; i < NCNT; i++) scountovf[FIRST_IDX + i] = of_v[i];
    end

    assign lcof_set = |lcof_v;

    // Address decode and read mux; unimplemented addresses read zero with no hit
    always_comb begin
        csr_hit  = 1'b0;
        csr_rdat = '0;
        for (int unsigned i = 0; i < NCNT; i++) begin
            if ((csr_addr == MHPMCOUNTER_BASE + 12'(i)) ||
                (csr_addr == HPMCOUNTER_BASE + 12'(i))) begin
                csr_hit  = 1'b1;
                csr_rdat = cnt_rd[i];
            end
            if (csr_addr == MHPMEVENT_BASE + 12'(i)) begin
                csr_hit  = 1'b1;
                csr_rdat = evt_rd[i];
            end
        end
`ifdef HPM_OVERFLOW_EN
        if (csr_addr == SCOUNTOVF_ADDR) begin
            csr_hit  = 1'b1;
            csr_rdat = 64'(scountovf);
        end
`endif
    end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Randomised and directed checks of hpm_counter_bank against a behavioural model.
// Builds with or without HPM_OVERFLOW_EN; expectations follow the same macro.
module tb_hpm_counter_bank;

    localparam int unsigned NCNT = 4;
    localparam int unsigned CW   = 64;
    localparam int unsigned NEVT = 16;
    localparam int unsigned EIW  = 2;
`ifdef HPM_OVERFLOW_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                csr_we;
    logic [11:0]         csr_addr;
    logic [63:0]         csr_wdat;
    logic [63:0]         csr_rdat;
    logic                csr_hit;
    logic [1:0]          level;
    logic [NCNT-1:0]     inhibit;
    logic [NEVT*EIW-1:0] evt;
    logic                lcof_set;
    logic [31:0]         scountovf;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model state
    logic [63:0]         m_cnt  [NCNT];
    logic [4:0]          m_sel  [NCNT];
    bit                  m_of   [NCNT];
    bit                  m_minh [NCNT];
    bit                  m_sinh [NCNT];
    bit                  m_uinh [NCNT];
    bit                  m_lcof;
    logic [NEVT*EIW-1:0] m_evt1;
    logic [1:0]          m_lvl1;
    logic [NCNT-1:0]     m_inh1;

    hpm_counter_bank #(
        .NCNT (NCNT),
        .CW   (CW),
        .NEVT (NEVT),
        .EIW  (EIW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .csr_we    (csr_we),
        .csr_addr  (csr_addr),
        .csr_wdat  (csr_wdat),
        .csr_rdat  (csr_rdat),
        .csr_hit   (csr_hit),
        .level     (level),
        .inhibit   (inhibit),
        .evt       (evt),
        .lcof_set  (lcof_set),
        .scountovf (scountovf)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] m_scountovf();
        logic [31:0] v = '0;
        for (int i = 0; i < NCNT; i++) v[3 + i] = m_of[i];
        return v;
    endfunction

    function automatic void m_read(input logic [11:0] a, output bit h, output logic [63:0] d);
        h = 1'b0;
        d = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (a == 12'hB03 + 12'(i) || a == 12'hC03 + 12'(i)) begin
                h = 1'b1;
                d = m_cnt[i];
            end
            if (a == 12'h323 + 12'(i)) begin
                h = 1'b1;
                d = {m_of[i], m_minh[i], m_sinh[i], m_uinh[i], 55'd0, m_sel[i]};
            end
        end
        if (OVF && a == 12'hDA0) begin
            h = 1'b1;
            d = 64'(m_scountovf());
        end
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NCNT; i++) begin
            m_cnt[i] = '0; m_sel[i] = '0; m_of[i] = 0;
            m_minh[i] = 0; m_sinh[i] = 0; m_uinh[i] = 0;
        end
        m_lcof = 0; m_evt1 = '0; m_lvl1 = '0; m_inh1 = '0;
    endtask

    // One clock edge: advance the model with the inputs the DUT saw, then check flags
    task automatic tick();
        logic                we;
        logic [11:0]         a;
        logic [63:0]         d;
        logic [NEVT*EIW-1:0] e;
        logic [1:0]          lv;
        logic [NCNT-1:0]     ih;
        @(posedge clk);
        we = csr_we; a = csr_addr; d = csr_wdat; e = evt; lv = level; ih = inhibit;
        m_lcof = 0;
        for (int i = 0; i < NCNT; i++) begin
            int unsigned inc;
            int unsigned v;
            bit          blk, wc, wev, ovf;
            logic [64:0] s;
            inc = 0;
            v = m_sel[i];
            if (v >= 1 && v <= NEVT) inc = m_evt1[(v - 1) * EIW +: EIW];
            blk = m_inh1[i];
            if (OVF && ((m_minh[i] && m_lvl1 == 2'b11) || (m_sinh[i] && m_lvl1 == 2'b01) ||
                        (m_uinh[i] && m_lvl1 == 2'b00))) blk = 1;
            wc  = we && (a == 12'hB03 + 12'(i));
            wev = we && (a == 12'h323 + 12'(i));
            s   = {1'b0, m_cnt[i]} + 65'(inc);
            ovf = OVF && !blk && !wc && s[64];
            if (wc) m_cnt[i] = d;
            else if (!blk) m_cnt[i] = s[63:0];
            if (ovf && !m_of[i]) m_lcof = 1;
            if (wev) begin
                m_sel[i]  = d[4:0];
                m_of[i]   = OVF && (d[63] || ovf);
                m_minh[i] = OVF && d[62];
                m_sinh[i] = OVF && d[61];
                m_uinh[i] = OVF && d[60];
            end else begin
                m_of[i] = m_of[i] || ovf;
            end
        end
        m_evt1 = e; m_lvl1 = lv; m_inh1 = ih;
        #1;
        chk("lcof_set", 64'(lcof_set), 64'(m_lcof));
        chk("scountovf", 64'(scountovf), 64'(m_scountovf()));
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdat = d;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [63:0] exp);
        csr_we = 1'b0; csr_addr = a;
        #1;
        chk(tag, csr_rdat, exp);
    endtask

    task automatic hit_chk(input string tag, input logic [11:0] a, input bit exp);
        csr_we = 1'b0; csr_addr = a;
        #1;
        chk(tag, 64'(csr_hit), 64'(exp));
    endtask

    task automatic rd_model(input logic [11:0] a);
        bit          h;
        logic [63:0] d;
        csr_we = 1'b0; csr_addr = a;
        #1;
        m_read(a, h, d);
        chk($sformatf("hit@%h", a), 64'(csr_hit), 64'(h));
        chk($sformatf("rdat@%h", a), csr_rdat, d);
    endtask

    // Asynchronous reset pulse between edges; everything must read zero while held
    task automatic do_reset();
        rst = 1'b0;
        #1;
        m_clear();
        chk("rst_lcof", 64'(lcof_set), 64'd0);
        chk("rst_ovf", 64'(scountovf), 64'd0);
        for (int i = 0; i < NCNT; i++) begin
            rd_chk("rst_cnt", 12'hB03 + 12'(i), 64'd0);
            rd_chk("rst_evt", 12'h323 + 12'(i), 64'd0);
        end
        rst = 1'b1;
    endtask

    // Preload counter 0 just below wrap, then let a pending +3 carry it over
    task automatic wrap3();
        evt = 32'h3;
        wr(12'hB03, 64'hFFFF_FFFF_FFFF_FFFE);
        evt = '0;
        tick();
        rd_chk("t4_wrap", 12'hB03, 64'd1);
    endtask

    initial begin
        rst = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdat = '0;
        level = 2'b00; inhibit = '0; evt = '0;
        #5;
        do_reset();

        // Four +3 pulses on line 0, two-cycle visibility, alias read
        wr(12'h323, 64'd1);
        evt = 32'h3;
        tick(); rd_chk("t2_lat0", 12'hB03, 64'd0);
        tick(); rd_chk("t2_lat1", 12'hB03, 64'd3);
        tick(); tick();
        evt = '0;
        tick(); tick();
        rd_chk("t2_cnt", 12'hB03, 64'd12);
        rd_chk("t2_alias", 12'hC03, 64'd12);
        wr(12'hC03, 64'd99);
        rd_chk("t2_alias_wr", 12'hB03, 64'd12);

        // Write beats coincident increment
        evt = 32'h3; tick();
        evt = '0;
        wr(12'hB03, 64'd5);
        rd_chk("t3_coll", 12'hB03, 64'd5);
        tick();
        rd_chk("t3_after", 12'hB03, 64'd5);

        // Wrap-around, overflow pulse, re-arm
        wrap3();
        chk("t4_lcof1", 64'(lcof_set), OVF ? 64'd1 : 64'd0);
        chk("t4_sovf", 64'(scountovf), OVF ? 64'h8 : 64'h0);
        rd_chk("t4_evt_of", 12'h323, OVF ? 64'h8000_0000_0000_0001 : 64'h1);
        tick();
        chk("t4_lcof_end", 64'(lcof_set), 64'd0);
        wrap3();
        chk("t4_lcof2", 64'(lcof_set), 64'd0);
        wr(12'h323, 64'd1);
        chk("t4_clr", 64'(scountovf), 64'h0);
        wrap3();
        chk("t4_lcof3", 64'(lcof_set), OVF ? 64'd1 : 64'd0);

        // Inhibit freezes; MINH at M-mode freezes, U-mode counts
        wr(12'hB03, 64'd0);
        inhibit = 4'b0001; evt = 32'h3;
        tick(); tick(); tick();
        evt = '0; tick();
        inhibit = '0; tick(); tick();
        rd_chk("t5_inh", 12'hB03, 64'd0);
        wr(12'h323, 64'h4000_0000_0000_0001);
        level = 2'b11; evt = 32'h3;
        tick(); tick(); tick();
        evt = '0; tick(); tick();
        rd_chk("t5_minh_m", 12'hB03, OVF ? 64'd0 : 64'd9);
        level = 2'b00; evt = 32'h3;
        tick();
        evt = '0; tick(); tick();
        rd_chk("t5_minh_u", 12'hB03, OVF ? 64'd3 : 64'd12);

        // Decode boundaries and out-of-range event select
        hit_chk("t6_hit326", 12'h326, 1'b1);
        hit_chk("t6_hit327", 12'h327, 1'b0);
        rd_chk("t6_rd327", 12'h327, 64'd0);
        hit_chk("t6_hitb07", 12'hB07, 1'b0);
        hit_chk("t6_hitda0", 12'hDA0, OVF);
        wr(12'h324, 64'd17);
        wr(12'hB04, 64'd0);
        evt = '1; tick(); tick(); tick();
        evt = '0; tick(); tick();
        rd_chk("t6_sel17", 12'hB04, 64'd0);
        rd_chk("t6_evt17", 12'h324, 64'd17);

        // Count, then reset mid-operation
        for (int i = 0; i < NCNT; i++) wr(12'h323 + 12'(i), 64'(i + 1));
        for (int c = 0; c < 20; c++) begin
            evt = $urandom;
            tick();
        end
        rd_chk("t1_pre", 12'hB03, m_cnt[0]);
        do_reset();
        evt = '0;
        tick();
        for (int i = 0; i < NCNT; i++) rd_chk("t1_post", 12'hB03 + 12'(i), 64'd0);

        // Randomised traffic against the model
        for (int c = 0; c < 2000; c++) begin
            int unsigned r   = $urandom_range(0, 15);
            int unsigned idx = $urandom_range(0, NCNT - 1);
            logic [11:0] ra;
            evt     = $urandom;
            level   = 2'($urandom_range(0, 3));
            inhibit = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
            case (r)
                0: begin
                    csr_we = 1'b1; csr_addr = 12'hB03 + 12'(idx);
                    csr_wdat = ($urandom_range(0, 1) == 1) ? {56'hFF_FFFF_FFFF_FFFF, 8'($urandom)}
                                                           : {32'($urandom), 32'($urandom)};
                end
                1: begin
                    csr_we = 1'b1; csr_addr = 12'h323 + 12'(idx);
                    csr_wdat = {4'($urandom), 55'({$urandom, $urandom}), 5'($urandom_range(0, 20))};
                end
                2: begin
                    csr_we = 1'b1; csr_addr = 12'hC03 + 12'(idx);
                    csr_wdat = {32'($urandom), 32'($urandom)};
                end
                3: begin
                    csr_we = 1'b1; csr_addr = 12'h327;
                    csr_wdat = {32'($urandom), 32'($urandom)};
                end
                default: csr_we = 1'b0;
            endcase
            tick();
            csr_we = 1'b0;
            case ($urandom_range(0, 4))
                0: ra = 12'hB03 + 12'($urandom_range(0, 4));
                1: ra = 12'hC03 + 12'($urandom_range(0, 4));
                2: ra = 12'h323 + 12'($urandom_range(0, 4));
                3: ra = 12'hDA0;
                default: ra = 12'($urandom);
            endcase
            rd_model(ra);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
